rq_arbiter: RTL and testbench

- Round-robin, packet-granular arbiter that shares the single RQ_gearbox256 user interface among N_REQ requesters (e.g. DMA read engine, DMA write engine, doorbell/MSI logic).
- Each requester presents a complete RQ request (descriptor plus payload beats, SOP/LAST framing) with valid/ready.
- A grant is held from the SOP beat through the LAST beat, so packets are never interleaved at the gearbox.

---
 rtl/rq_arbiter_if.sv | 26 ++
 rtl/rq_arbiter.sv | 129 ++++++++++++
 tb/tb_rq_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rq_arbiter_if.sv
// Gearbox-side request stream of the RQ arbiter: one descriptor/payload beat per handshake.
// A beat transfers on a cycle where rq_valid and rq_ready are both high; the master holds every field stable while rq_valid is high and rq_ready is low.
interface rq_arbiter_if #(
  parameter int DESC_W = 128,
  parameter int DATA_W = 256
);
  logic [DESC_W-1:0] descriptor;
  logic [DATA_W-1:0] rq_payload;
  logic [10:0]       rq_payload_dw_count;
  logic              rq_payload_sop;
  logic              rq_payload_last;
  logic              rq_valid;
  logic              rq_ready;

  modport master (
    output descriptor, rq_payload, rq_payload_dw_count,
    output rq_payload_sop, rq_payload_last, rq_valid,
    input  rq_ready
  );

  modport slave (
    input  descriptor, rq_payload, rq_payload_dw_count,
    input  rq_payload_sop, rq_payload_last, rq_valid,
    output rq_ready
  );
endinterface

// File: rtl/rq_arbiter.sv
// Packet-granular round-robin arbiter: N_REQ requesters share one RQ gearbox stream.
// A grant is held from the SOP beat through the LAST beat, so packets never interleave.
module rq_arbiter #(
  parameter int  N_REQ  = 4,
  parameter int  DESC_W = 128,
  parameter int  DATA_W = 256,
  localparam int GW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ*DESC_W-1:0] req_descriptor,
  input  logic [N_REQ*DATA_W-1:0] req_payload,
  input  logic [N_REQ*11-1:0]     req_dw_count,
  input  logic [N_REQ-1:0]        req_sop,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  rq_arbiter_if.master            rq,
  output logic [GW-1:0]           grant_id,
  output logic                    busy,
  output logic                    proto_err,
  output logic                    dbg_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [GW-1:0] r_grant, w_grant_nxt;
  logic [GW-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic          r_proto_err, w_proto_err_nxt;
  logic          r_seen, w_seen_nxt;   // a beat of the current packet has already been accepted
  logic          r_pend, w_pend_nxt;   // granted beat was offered last cycle but stalled
  logic          w_found;
  logic [GW-1:0] w_pick;
  logic [GW:0]   w_sum;
  logic          w_hs;

  // Round-robin search: first requester with valid&sop, starting just after r_rr_ptr.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (GW+1)'(k);
      if (w_sum >= (GW+1)'(N_REQ)) begin
        w_sum = w_sum - (GW+1)'(N_REQ);
      end
      if (!w_found && req_valid[w_sum[GW-1:0]] && req_sop[w_sum[GW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[GW-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_proto_err_nxt = r_proto_err;
    w_seen_nxt      = r_seen;
    w_pend_nxt      = r_pend;
    w_hs            = 1'b0;
    req_ready              = '0;
    rq.rq_valid            = 1'b0;
    rq.descriptor          = '0;
    rq.rq_payload          = '0;
    rq.rq_payload_dw_count = '0;
    rq.rq_payload_sop      = 1'b0;
    rq.rq_payload_last     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_pick;
          w_state_nxt = S_XFER;
          w_seen_nxt  = 1'b0;
          w_pend_nxt  = 1'b0;
        end
      end
      S_XFER: begin
        rq.descriptor          = req_descriptor[int'(r_grant)*DESC_W +: DESC_W];
        rq.rq_payload          = req_payload[int'(r_grant)*DATA_W +: DATA_W];
        rq.rq_payload_dw_count = req_dw_count[int'(r_grant)*11 +: 11];
        rq.rq_payload_sop      = req_sop[r_grant];
        rq.rq_payload_last     = req_last[r_grant];
        rq.rq_valid            = req_valid[r_grant];
        req_ready[r_grant]     = rq.rq_ready;
        w_hs = req_valid[r_grant] & rq.rq_ready;
        // A repeated SOP inside a packet, or withdrawing a stalled beat, is flagged but not acted on.
        if ((w_hs && r_seen && req_sop[r_grant]) || (r_pend && !req_valid[r_grant])) begin
          w_proto_err_nxt = 1'b1;
        end
        w_seen_nxt = r_seen | w_hs;
        w_pend_nxt = req_valid[r_grant] & ~rq.rq_ready;
        if (w_hs && req_last[r_grant]) begin
          w_state_nxt  = S_IDLE;
          w_rr_ptr_nxt = r_grant;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= GW'(N_REQ - 1);
      r_proto_err <= 1'b0;
      r_seen      <= 1'b0;
      r_pend      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_proto_err <= w_proto_err_nxt;
      r_seen      <= w_seen_nxt;
      r_pend      <= w_pend_nxt;
    end
  end

  assign grant_id  = r_grant;
  assign busy      = (r_state == S_XFER);
  assign proto_err = r_proto_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_rq_arbiter.sv
// Bench for rq_arbiter: packet-level requester drivers, a per-cycle reference model and directed scenarios.
module tb_rq_arbiter;
  localparam int N  = 4;
  localparam int DW = 128;
  localparam int PW = 256;
  localparam int GW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*DW-1:0] req_descriptor;
  logic [N*PW-1:0] req_payload;
  logic [N*11-1:0] req_dw_count;
  logic [N-1:0]    req_sop, req_last, req_valid, req_ready;
  logic [GW-1:0]   grant_id;
  logic            busy, proto_err, dbg_state;
  logic            rq_ready_drv;

  rq_arbiter_if #(.DESC_W(DW), .DATA_W(PW)) rq_if ();
  assign rq_if.rq_ready = rq_ready_drv;

  rq_arbiter #(.N_REQ(N), .DESC_W(DW), .DATA_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_descriptor(req_descriptor), .req_payload(req_payload), .req_dw_count(req_dw_count),
    .req_sop(req_sop), .req_last(req_last), .req_valid(req_valid), .req_ready(req_ready),
    .rq(rq_if.master),
    .grant_id(grant_id), .busy(busy), .proto_err(proto_err), .dbg_state(dbg_state)
  );

  // ---------------- requester drivers ----------------
  typedef struct {
    int len; logic [10:0] dw; logic [DW-1:0] desc; logic [31:0] base;
    bit bad_sop; bit drop; int gap;
  } pkt_t;

  logic [DW-1:0] d_desc [N];
  logic [PW-1:0] d_pay  [N];
  logic [10:0]   d_dw   [N];
  logic [N-1:0]  d_valid, d_sop, d_last;

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign req_descriptor[gi*DW +: DW] = d_desc[gi];
    assign req_payload[gi*PW +: PW]    = d_pay[gi];
    assign req_dw_count[gi*11 +: 11]   = d_dw[gi];
  end
  assign req_valid = d_valid;
  assign req_sop   = d_sop;
  assign req_last  = d_last;

  pkt_t pq [N][$];
  pkt_t cur [N];
  bit   act [N];
  bit   acc [N];
  bit   noise [N];
  int   bidx [N];
  int   waited [N];
  int   sop_cyc [N];
  int   cyc;
  bit   rand_mode;
  int   force_lo;

  // ---------------- reference model + scoreboard ----------------
  bit m_busy, m_err, m_seen, m_pend;
  int m_grant, m_rr;
  int            acc_id [$];
  logic [31:0]   acc_pay [$];
  logic [DW-1:0] acc_desc [$];
  int            acc_cyc [$];
  logic [31:0]   exp_q [$];
  int n_cmp, n_bad;

  task automatic check(string name, logic [PW-1:0] a, logic [PW-1:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, a, e);
    end
  endtask

  task automatic push(int i, int len, logic [10:0] dw, logic [DW-1:0] desc, logic [31:0] base,
                      bit bad_sop, bit drop, int gap);
    pkt_t p;
    p.len = len; p.dw = dw; p.desc = desc; p.base = base;
    p.bad_sop = bad_sop; p.drop = drop; p.gap = gap;
    pq[i].push_back(p);
  endtask

  task automatic present(int i);
    d_valid[i] = 1'b1;
    d_sop[i]   = (bidx[i] == 0) || (cur[i].bad_sop && bidx[i] == 1);
    d_last[i]  = (bidx[i] == cur[i].len - 1);
    d_pay[i]   = {224'b0, cur[i].base + 32'(bidx[i])};
    d_dw[i]    = cur[i].dw;
    d_desc[i]  = cur[i].desc;
    if (bidx[i] == 0) sop_cyc[i] = cyc;
  endtask

  task automatic drive_inputs();
    bit was_acc;
    if (force_lo > 0) begin
      rq_ready_drv = 1'b0;
      force_lo--;
    end else begin
      rq_ready_drv = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      was_acc = acc[i];
      acc[i] = 1'b0;
      if (act[i] && was_acc) begin
        bidx[i]++;
        if (bidx[i] == cur[i].len) begin
          act[i] = 1'b0; d_valid[i] = 1'b0; d_sop[i] = 1'b0; d_last[i] = 1'b0;
        end
      end
      if (act[i]) begin
        if (was_acc) begin
          if (rand_mode && $urandom_range(0, 7) == 0) d_valid[i] = 1'b0;
          else present(i);
        end else if (!d_valid[i]) begin
          present(i);
        end else if (cur[i].drop && bidx[i] > 0) begin
          d_valid[i] = 1'b0;
          cur[i].drop = 1'b0;
        end
      end else if (pq[i].size() > 0) begin
        if (waited[i] < pq[i][0].gap) begin
          waited[i]++;
          d_valid[i] = 1'b0;
        end else begin
          cur[i] = pq[i].pop_front();
          waited[i] = 0; act[i] = 1'b1; bidx[i] = 0;
          present(i);
        end
      end else begin
        d_valid[i] = noise[i]; d_sop[i] = 1'b0; d_last[i] = 1'b0;
      end
    end
  endtask

  // Expected outputs follow from the model's grant; the model then applies the cycle's handshake.
  task automatic model_cmp();
    logic [N-1:0] e_ready; logic e_valid, e_sop, e_last;
    logic [DW-1:0] e_desc; logic [PW-1:0] e_pay; logic [10:0] e_dw;
    bit hs, found; int g, idx;
    if (!rst_n) begin
      m_busy = 0; m_grant = 0; m_rr = N - 1; m_err = 0; m_seen = 0; m_pend = 0;
    end
    e_ready = '0; e_valid = 0; e_sop = 0; e_last = 0; e_desc = '0; e_pay = '0; e_dw = '0;
    g = m_grant;
    if (m_busy) begin
      e_valid = d_valid[g]; e_ready[g] = rq_ready_drv; e_desc = d_desc[g];
      e_pay = d_pay[g]; e_dw = d_dw[g]; e_sop = d_sop[g]; e_last = d_last[g];
    end
    check("req_ready", PW'(req_ready), PW'(e_ready));
    check("rq_valid", PW'(rq_if.rq_valid), PW'(e_valid));
    check("descriptor", PW'(rq_if.descriptor), PW'(e_desc));
    check("payload", rq_if.rq_payload, e_pay);
    check("dw_count", PW'(rq_if.rq_payload_dw_count), PW'(e_dw));
    check("sop", PW'(rq_if.rq_payload_sop), PW'(e_sop));
    check("last", PW'(rq_if.rq_payload_last), PW'(e_last));
    check("grant_id", PW'(grant_id), PW'(m_grant));
    check("busy", PW'(busy), PW'(m_busy));
    check("dbg_state", PW'(dbg_state), PW'(m_busy));
    check("proto_err", PW'(proto_err), PW'(m_err));
    if (!rst_n) return;
    if (!m_busy) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        idx = (m_rr + k) % N;
        if (!found && d_valid[idx] && d_sop[idx]) begin
          found = 1; m_busy = 1; m_grant = idx; m_seen = 0; m_pend = 0;
        end
      end
    end else begin
      hs = d_valid[g] && rq_ready_drv;
      if (hs) begin
        acc[g] = 1'b1;
        acc_id.push_back(g); acc_pay.push_back(d_pay[g][31:0]);
        acc_desc.push_back(d_desc[g]); acc_cyc.push_back(cyc);
      end
      if ((hs && m_seen && d_sop[g]) || (m_pend && !d_valid[g])) m_err = 1;
      m_seen = m_seen | hs;
      m_pend = d_valid[g] && !rq_ready_drv;
      if (hs && d_last[g]) begin
        m_busy = 0; m_rr = g;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    cyc++;
    drive_inputs();
    @(negedge clk);
    model_cmp();
  endtask

  function automatic bit all_idle();
    bit r = !m_busy;
    for (int i = 0; i < N; i++) if (act[i] || pq[i].size() > 0) r = 0;
    return r;
  endfunction

  task automatic run_until_idle(int budget);
    int n = 0;
    while (!all_idle()) begin
      cycle();
      n++;
      if (n > budget) begin
        n_cmp++; n_bad++;
        $display("FAIL timeout: still busy after %0d cycles, required idle within %0d", n, budget);
        break;
      end
    end
  endtask

  task automatic reset_drivers();
    for (int i = 0; i < N; i++) begin
      pq[i].delete();
      act[i] = 0; acc[i] = 0; noise[i] = 0; bidx[i] = 0; waited[i] = 0; sop_cyc[i] = 0;
      d_desc[i] = '0; d_pay[i] = '0; d_dw[i] = '0;
    end
    d_valid = '0; d_sop = '0; d_last = '0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int s, n;
    logic [DW-1:0] desc_a;
    n_cmp = 0; n_bad = 0; cyc = 0; rand_mode = 0; force_lo = 0;
    rq_ready_drv = 1'b1;
    reset_drivers();
    repeat (2) @(posedge clk);
    @(negedge clk); model_cmp();
    check("rst_grant", PW'(grant_id), PW'(0));
    @(posedge clk); #1; rst_n = 1'b1;

    // All four single-beat packets at once: grants 0,1,2,3 every other cycle.
    s = acc_id.size();
    for (int i = 0; i < N; i++) push(i, 1, 11'(i + 1), {4{$urandom}}, 32'h1000 + i, 0, 0, 0);
    run_until_idle(50);
    for (int k = 0; k < N; k++) begin
      check("t2_order", PW'(acc_id[s+k]), PW'(k));
      check("t2_timing", PW'(acc_cyc[s+k] - sop_cyc[0]), PW'(1 + 2*k));
    end

    // Single requester, single beat.
    desc_a = 128'hAAAA_BBBB_CCCC_DDDD_1111_2222_3333_4444;
    push(0, 1, 11'd1, desc_a, 32'hDEAD0001, 0, 0, 0);
    run_until_idle(20);
    check("t1_id", PW'(acc_id[$]), PW'(0));
    check("t1_pay", PW'(acc_pay[$]), PW'(32'hDEAD0001));
    check("t1_desc", PW'(acc_desc[$]), PW'(desc_a));
    check("t1_latency", PW'(acc_cyc[$] - sop_cyc[0]), PW'(1));

    // Valid without SOP is never eligible.
    s = acc_id.size();
    noise[3] = 1;
    repeat (10) cycle();
    check("noise_busy", PW'(busy), PW'(0));
    check("noise_acc", PW'(acc_id.size()), PW'(s));
    noise[3] = 0;
    cycle();

    // Packet lock: req0 raises SOP during req1's packet and must wait for its LAST.
    s = acc_id.size();
    push(1, 2, 11'd9, {4{$urandom}}, 32'hDEAD0008, 0, 0, 0);
    push(0, 1, 11'd1, {4{$urandom}}, 32'hC0DE0000, 0, 0, 2);
    run_until_idle(30);
    exp_q = '{32'hDEAD0008, 32'hDEAD0009, 32'hC0DE0000};
    for (int k = 0; k < 3; k++) check("t3_pay", PW'(acc_pay[s+k]), PW'(exp_q[k]));
    check("t3_last_id", PW'(acc_id[s+2]), PW'(0));

    // Back-pressure: 3 stall cycles after the first beat of a 3-beat req2 packet.
    s = acc_id.size();
    push(2, 3, 11'd20, {4{$urandom}}, 32'h22220000, 0, 0, 0);
    n = 0;
    while (acc_id.size() == s && n < 20) begin cycle(); n++; end
    force_lo = 3;
    run_until_idle(30);
    exp_q = '{32'h22220000, 32'h22220001, 32'h22220002};
    for (int k = 0; k < 3; k++) check("t4_pay", PW'(acc_pay[s+k]), PW'(exp_q[k]));
    check("t4_stall", PW'(acc_cyc[s+1] - acc_cyc[s]), PW'(4));
    check("t4_err", PW'(proto_err), PW'(0));

    // Fairness: after req3 completes, req0 beats req3.
    push(3, 1, 11'd2, {4{$urandom}}, 32'h33330000, 0, 0, 0);
    run_until_idle(20);
    s = acc_id.size();
    push(0, 1, 11'd2, {4{$urandom}}, 32'hA0A00000, 0, 0, 0);
    push(3, 1, 11'd2, {4{$urandom}}, 32'hA3A30000, 0, 0, 0);
    run_until_idle(20);
    check("t5_first", PW'(acc_id[s]), PW'(0));
    check("t5_second", PW'(acc_id[s+1]), PW'(3));

    // Repeated SOP sets the sticky error; reset mid-packet clears everything.
    push(1, 2, 11'd4, {4{$urandom}}, 32'hB0B00000, 1, 0, 0);
    run_until_idle(20);
    check("t6_err_model", PW'(m_err), PW'(1));
    check("t6_err", PW'(proto_err), PW'(1));
    push(2, 6, 11'd40, {4{$urandom}}, 32'hE0E00000, 0, 0, 0);
    repeat (4) cycle();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_ready", PW'(req_ready), PW'(0));
    check("rst_valid", PW'(rq_if.rq_valid), PW'(0));
    check("rst_payload", rq_if.rq_payload, PW'(0));
    check("rst_desc", PW'(rq_if.descriptor), PW'(0));
    check("rst_busy", PW'(busy), PW'(0));
    check("rst_err", PW'(proto_err), PW'(0));
    reset_drivers();
    @(negedge clk); model_cmp();
    @(posedge clk); #1; rst_n = 1'b1;
    s = acc_id.size();
    push(0, 2, 11'd5, {4{$urandom}}, 32'h50500000, 0, 0, 0);
    run_until_idle(20);
    check("t6_post_cnt", PW'(acc_id.size() - s), PW'(2));
    check("t6_post_pay", PW'(acc_pay[$]), PW'(32'h50500001));
    check("t6_post_err", PW'(proto_err), PW'(0));

    // Randomized traffic with back-pressure, gaps and occasional protocol violations.
    rand_mode = 1;
    for (int p = 0; p < 300; p++) begin
      push($urandom_range(0, N-1), $urandom_range(1, 5), 11'($urandom_range(1, 2047)),
           {4{$urandom}}, $urandom, ($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0),
           $urandom_range(0, 3));
    end
    run_until_idle(20000);
    rand_mode = 0;
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
